// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall/flush controller for a five-stage core.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_mem,
    input  logic        stall_br,
    input  logic        br_taken,
    input  logic        icache_miss,
    input  logic        dcache_miss,
    input  logic        halt_id,
    input  logic        halt_wb,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic [2:0]  dbgState
);

    typedef enum logic [2:0] {
        RUN        = 3'd0,
        MEM_WAIT   = 3'd1,
        FETCH_WAIT = 3'd2,
        DRAIN      = 3'd3,
        HALTED     = 3'd4
    } state_t;

    state_t state;
    state_t nextState;
    state_t baseState;
    logic   pendFlush;
    logic   pendNext;
    logic   draining;
    logic   drainNext;

    // Where the FSM settles once nothing higher-priority holds it.
    always_comb begin
        if (draining)
            baseState = DRAIN;
        else if (icache_miss)
            baseState = FETCH_WAIT;
        else
            baseState = RUN;
    end

    always_comb begin
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        idex_we    = 1'b0;
        exmem_we   = 1'b0;
        memwb_we   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        nextState  = state;
        pendNext   = pendFlush;
        drainNext  = draining;

        if (!rst_n || state == HALTED) begin
            // everything frozen
        end else begin
            if (dcache_miss) begin
                nextState = MEM_WAIT;
                // A branch resolved while frozen must still kill the wrong-path fetch later.
                if (br_taken && !draining)
                    pendNext = 1'b1;
            end else if (pendFlush) begin
                {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                ifid_flush = 1'b1;
                pendNext   = 1'b0;
                nextState  = baseState;
            end else if (stall_mem || stall_br) begin
                {idex_we, exmem_we, memwb_we} = 3'b111;
                idex_flush = 1'b1;
                nextState  = baseState;
            end else if (draining) begin
                {ifid_we, idex_we, exmem_we, memwb_we} = 4'b1111;
                ifid_flush = 1'b1;
                nextState  = DRAIN;
            end else if (br_taken) begin
                {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                ifid_flush = 1'b1;
                nextState  = baseState;
            end else if (halt_id) begin
                // Halt beats an icache miss so the HLT is not lost behind a fetch bubble.
                {ifid_we, idex_we, exmem_we, memwb_we} = 4'b1111;
                ifid_flush = 1'b1;
                drainNext  = 1'b1;
                nextState  = DRAIN;
            end else if (icache_miss) begin
                {ifid_we, idex_we, exmem_we, memwb_we} = 4'b1111;
                ifid_flush = 1'b1;
                nextState  = FETCH_WAIT;
            end else begin
                {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = 5'b11111;
                nextState = RUN;
            end

            if (halt_wb)
                nextState = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            pendFlush <= 1'b0;
            draining  <= 1'b0;
        end else begin
            state     <= nextState;
            pendFlush <= pendNext;
            draining  <= drainNext;
        end
    end

    assign halted   = (state == HALTED);
    assign dbgState = state;

`ifdef PIPE_PERF_CNT_EN
    logic stallInc;
    logic flushInc;

    assign stallInc = (state != HALTED) && !pc_we;
    // Only branch-driven flushes redirect the PC while flushing IF/ID.
    assign flushInc = ifid_flush && pc_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 16'h0000;
            flush_count  <= 16'h0000;
        end else begin
            if (stallInc && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'h0001;
            if (flushInc && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'h0001;
        end
    end
`else
    assign stall_cycles = 16'h0000;
    assign flush_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected output vectors are queued by the driver
// and checked by a negedge monitor; counters are checked at fixed points.
`timescale 1ns/1ps
module tb_pipe_ctrl;

    localparam int W = 11;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // input bundle: {stall_mem, stall_br, br_taken, icache_miss, dcache_miss, halt_id, halt_wb}
    localparam logic [6:0] I_IDLE = 7'b0000000;
    localparam logic [6:0] I_SMEM = 7'b1000000;
    localparam logic [6:0] I_SBR  = 7'b0100000;
    localparam logic [6:0] I_BR   = 7'b0010000;
    localparam logic [6:0] I_IC   = 7'b0001000;
    localparam logic [6:0] I_DC   = 7'b0000100;
    localparam logic [6:0] I_HID  = 7'b0000010;
    localparam logic [6:0] I_HWB  = 7'b0000001;

    // output bundle: {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}
    localparam logic [6:0] O_ZERO  = 7'b0000000;
    localparam logic [6:0] O_RUN   = 7'b1111100;
    localparam logic [6:0] O_STALL = 7'b0011101;
    localparam logic [6:0] O_BR    = 7'b1111110;
    localparam logic [6:0] O_FLUSH = 7'b0111110;

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_MEM   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic        clk;
    logic        rstN;
    logic        stallMem, stallBr, brTaken, icacheMiss, dcacheMiss, haltId, haltWb;
    logic        pcWe, ifidWe, idexWe, exmemWe, memwbWe, ifidFlush, idexFlush, haltedO;
    logic [15:0] stallCycles, flushCount;
    logic [2:0]  dbgState;

    logic [W-1:0] expQ[$];
    int           nChecks = 0;
    int           nFails  = 0;
    int           vecIdx  = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst_n        (rstN),
        .stall_mem    (stallMem),
        .stall_br     (stallBr),
        .br_taken     (brTaken),
        .icache_miss  (icacheMiss),
        .dcache_miss  (dcacheMiss),
        .halt_id      (haltId),
        .halt_wb      (haltWb),
        .pc_we        (pcWe),
        .ifid_we      (ifidWe),
        .idex_we      (idexWe),
        .exmem_we     (exmemWe),
        .memwb_we     (memwbWe),
        .ifid_flush   (ifidFlush),
        .idex_flush   (idexFlush),
        .halted       (haltedO),
        .stall_cycles (stallCycles),
        .flush_count  (flushCount),
        .dbgState     (dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] exp;
        logic [W-1:0] act;
        if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            act = {dbgState, haltedO, pcWe, ifidWe, idexWe, exmemWe, memwbWe, ifidFlush, idexFlush};
            nChecks++;
            if (act !== exp) begin
                nFails++;
                $display("FAIL vec%0d {state,halted,pc,ifid,idex,exmem,memwb,ifl,idfl}: got %b, expected %b",
                         vecIdx, act, exp);
            end
            vecIdx++;
        end
    end

    // driver: apply one cycle of inputs and queue the expected outputs for it
    task automatic step(input logic rst, input logic [6:0] in, input logic [2:0] st,
                        input logic hlt, input logic [6:0] outs);
        rstN = rst;
        {stallMem, stallBr, brTaken, icacheMiss, dcacheMiss, haltId, haltWb} = in;
        expQ.push_back({st, hlt, outs});
        @(posedge clk);
        #1;
    endtask

    task automatic checkCnt(input string name, input logic [15:0] act, input logic [15:0] raw);
        logic [15:0] exp;
        exp = PERF ? raw : 16'h0000;
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic report();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    endtask

    initial begin
        #5000000;
        nFails++;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        report();
        $finish;
    end

    initial begin
        logic [6:0] haltMix[10];
        haltMix = '{I_IDLE, I_SMEM, I_BR, I_IC, I_DC, I_HID, I_HWB, I_SBR, 7'h7F, I_IDLE};

        rstN = 1'b0;
        {stallMem, stallBr, brTaken, icacheMiss, dcacheMiss, haltId, haltWb} = I_IDLE;
        @(posedge clk);
        #1;

        // reset holds everything off regardless of inputs
        step(1'b0, I_IDLE,      S_RUN, 1'b0, O_ZERO);
        step(1'b0, I_BR | I_DC, S_RUN, 1'b0, O_ZERO);
        checkCnt("stall_reset", stallCycles, 16'd0);
        checkCnt("flush_reset", flushCount, 16'd0);
        step(1'b1, I_IDLE, S_RUN, 1'b0, O_RUN);
        step(1'b1, I_IDLE, S_RUN, 1'b0, O_RUN);

        // hazard stalls
        step(1'b1, I_SMEM, S_RUN, 1'b0, O_STALL);
        checkCnt("stall_after_smem", stallCycles, 16'd1);
        step(1'b1, I_SBR, S_RUN, 1'b0, O_STALL);
        checkCnt("stall_after_sbr", stallCycles, 16'd2);

        // branch during dcache miss becomes a deferred flush
        step(1'b1, I_BR | I_DC, S_RUN, 1'b0, O_ZERO);
        step(1'b1, I_BR | I_DC, S_MEM, 1'b0, O_ZERO);
        step(1'b1, I_BR | I_DC, S_MEM, 1'b0, O_ZERO);
        step(1'b1, I_IDLE,      S_MEM, 1'b0, O_BR);
        step(1'b1, I_IDLE,      S_RUN, 1'b0, O_RUN);
        checkCnt("flush_after_pend", flushCount, 16'd1);
        checkCnt("stall_after_dmiss", stallCycles, 16'd5);

        // plain branch
        step(1'b1, I_BR,   S_RUN, 1'b0, O_BR);
        step(1'b1, I_IDLE, S_RUN, 1'b0, O_RUN);
        checkCnt("flush_after_br", flushCount, 16'd2);

        // icache miss for 5 cycles
        step(1'b1, I_IC, S_RUN, 1'b0, O_FLUSH);
        for (int i = 0; i < 4; i++)
            step(1'b1, I_IC, S_FETCH, 1'b0, O_FLUSH);
        step(1'b1, I_IDLE, S_FETCH, 1'b0, O_RUN);
        step(1'b1, I_IDLE, S_RUN,   1'b0, O_RUN);
        checkCnt("stall_after_imiss", stallCycles, 16'd10);
        checkCnt("flush_after_imiss", flushCount, 16'd2);

        // dcache miss ending while icache miss still pending
        step(1'b1, I_DC | I_IC, S_RUN,   1'b0, O_ZERO);
        step(1'b1, I_IC,        S_MEM,   1'b0, O_FLUSH);
        step(1'b1, I_IDLE,      S_FETCH, 1'b0, O_RUN);
        step(1'b1, I_IDLE,      S_RUN,   1'b0, O_RUN);
        checkCnt("stall_after_di", stallCycles, 16'd12);

        // halt: drain (branches ignored, dcache returns to DRAIN) then halted for 10 cycles
        step(1'b1, I_HID,       S_RUN,   1'b0, O_FLUSH);
        step(1'b1, I_DC | I_BR, S_DRAIN, 1'b0, O_ZERO);
        step(1'b1, I_BR,        S_MEM,   1'b0, O_FLUSH);
        step(1'b1, I_HWB,       S_DRAIN, 1'b0, O_FLUSH);
        for (int i = 0; i < 10; i++)
            step(1'b1, haltMix[i], S_HALT, 1'b1, O_ZERO);
        checkCnt("stall_after_halt", stallCycles, 16'd16);
        checkCnt("flush_after_halt", flushCount, 16'd2);

        // reset leaves HALTED
        step(1'b0, I_IDLE, S_RUN, 1'b0, O_ZERO);
        checkCnt("stall_reset2", stallCycles, 16'd0);

        // reset during MEM_WAIT with a pending flush
        step(1'b1, I_DC | I_BR, S_RUN, 1'b0, O_ZERO);
        step(1'b1, I_DC,        S_MEM, 1'b0, O_ZERO);
        checkCnt("stall_before_reset3", stallCycles, 16'd2);
        step(1'b0, I_IDLE, S_RUN, 1'b0, O_ZERO);
        checkCnt("stall_reset3", stallCycles, 16'd0);
        step(1'b1, I_IDLE, S_RUN, 1'b0, O_RUN);
        step(1'b1, I_IDLE, S_RUN, 1'b0, O_RUN);
        checkCnt("flush_after_reset3", flushCount, 16'd0);
        checkCnt("stall_after_reset3", stallCycles, 16'd0);

        // counter saturation
        stallMem = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        checkCnt("stall_saturated", stallCycles, 16'hFFFF);
        stallMem = 1'b0;

        for (int i = 0; i < 20 && expQ.size() > 0; i++)
            @(posedge clk);
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL queue_drain: got %0d entries left, expected 0", expQ.size());
        end

        report();
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  async active-low reset.
REQ-004 SHALL have port stall_mem  input  1  load-to-use hazard from hazard detect.
REQ-005 SHALL have port stall_br  input  1  branch operand/flag not ready, from hazard detect.
REQ-006 SHALL have port br_taken  input  1  branch resolved taken in ID this cycle.
REQ-007 SHALL have port icache_miss  input  1  fetch not ready; held high until fill done.
REQ-008 SHALL have port dcache_miss  input  1  MEM-stage access not ready; held high until done.
REQ-009 SHALL have port halt_id / halt_wb  input  1 each  HLT decoded in ID / HLT reached WB.
REQ-010 SHALL have outputs pc_we, ifid_we, idex_we, exmem_we, memwb_we  output  1 each  stage register write enables.
REQ-011 SHALL have outputs ifid_flush, idex_flush  output  1 each  load NOP into that stage register.
REQ-012 SHALL have port halted  output  1  core stopped, sticky.
REQ-013 SHALL have ports stall_cycles, flush_count  output  16 each  performance counters.

Function
REQ-014 SHALL implement registered FSM states RUN, MEM_WAIT, FETCH_WAIT, DRAIN, HALTED; control outputs combinational from state and inputs, same cycle.
REQ-015 SHALL, in any non-HALTED state, give dcache_miss top priority: all *_we=0, both flushes=0, state MEM_WAIT; next state on deassert: RUN, or FETCH_WAIT if icache_miss is high.
REQ-016 SHALL, with no dcache_miss and stall_mem or stall_br high: pc_we=0, ifid_we=0, idex_flush=1, other *_we=1.
REQ-017 SHALL, with no dcache_miss/hazard stall and br_taken high: pc_we=1, ifid_flush=1 for exactly one cycle.
REQ-018 SHALL, with icache_miss high and no higher-priority event: pc_we=0, ifid_flush=1, downstream *_we=1; state FETCH_WAIT until deassert.
REQ-019 SHALL latch a br_taken coinciding with dcache_miss into pend_flush and assert ifid_flush in the first cycle after dcache_miss falls; pend_flush then clears.
REQ-020 SHALL on halt_id (no stall active) enter DRAIN: pc_we=0, ifid_flush=1 every cycle, downstream drains.
REQ-021 SHALL on halt_wb enter HALTED next edge; HALTED: all *_we=0, flushes=0, halted=1, no exit except reset.
REQ-022 SHALL ignore br_taken and halt_id while in DRAIN; dcache_miss in DRAIN stalls as REQ-015 and returns to DRAIN.
REQ-023 SHALL in RUN with no events drive all *_we=1, flushes=0.
REQ-024 SHALL count stall_cycles +1 each cycle pc_we=0 outside HALTED; flush_count +1 per cycle ifid_flush=1 due to branch; both saturate at 16'hFFFF.

Reset
REQ-025 SHALL on rst_n low immediately: state RUN, pend_flush=0, halted=0, counters 0.
REQ-026 SHALL drive all *_we=0 and flushes=0 while rst_n low; normal operation from first edge after release.
REQ-027 SHALL abandon any MEM_WAIT/DRAIN/HALTED on reset mid-operation with no pending flush retained.

Configuration
REQ-028 SHALL compile counters only when PIPE_PERF_CNT_EN is defined; undefined: stall_cycles and flush_count ports remain, tied to 16'h0000, no counter flops.

Verification
REQ-029 SHALL test: stall_mem=1 for 1 cycle -> pc_we=0, ifid_we=0, idex_flush=1 that cycle; stall_cycles 0->1.
REQ-030 SHALL test: br_taken=1 with dcache_miss=1 for 3 cycles -> all we=0 for 3 cycles, ifid_flush=1 on cycle 4 only, flush_count=1.
REQ-031 SHALL test: halt_id then halt_wb 3 cycles later -> pc_we=0 during DRAIN, halted=1 next edge and stays 1 for 10 cycles.
REQ-032 SHALL test: icache_miss 5 cycles -> state FETCH_WAIT, pc_we=0 and ifid_flush=1 for 5 cycles, memwb_we=1 throughout.
REQ-033 SHALL test: 70000 stall cycles with PIPE_PERF_CNT_EN -> stall_cycles=16'hFFFF; without the macro -> 16'h0000.
REQ-034 SHALL test: rst_n low during MEM_WAIT with pend_flush set -> state RUN, no ifid_flush after release, counters 0.
